imsic_msi_dispatch: RTL and testbench
=====================================

# imsic_msi_dispatch

Bus-side MSI dispatcher that feeds the IMSIC per-hart CSR gates. It accepts MSI writes, decodes the target interrupt file and interrupt identity, and buffers accepted messages in a small FIFO. It then replays them one at a time as a shared `setipnum` bus plus a one-hot, level-stretched `setipnum_vld`. The stretch lets each hart's clock-domain synchroniser and rising-edge detector catch every message.

## Interface
- `NR_INTP_FILES`, 7, files per hart (M, S, VS1..VSn)
- `NR_HARTS`, 4, harts served
- `NR_SRC`, 32, implemented interrupt identities (1..NR_SRC-1 valid)
- `NR_SRC_WIDTH`, $clog2(NR_SRC), identity width
- `NR_TOTAL_INTFS`, NR_HARTS*NR_INTP_FILES, flat file count
- `ADDR_WIDTH`, 32, MSI address width
- `BASE_ADDR`, 32'h0, address of flat file page 0
- `FIFO_DEPTH`, 4, buffered messages (power of 2, ≥2)
- `HOLD_CYCLES`, 4, cycles `setipnum_vld` stays high (≥2)
- `GAP_CYCLES`, 4, low cycles between messages (≥2)

Ports:
- `clk`  in  1  block clock
- `rstn`  in  1  reset; asynchronous, active-low
- `i_msi_vld`  in  1  MSI write valid
- `o_msi_rdy`  out  1  MSI write ready
- `i_msi_addr`  in  ADDR_WIDTH  MSI target address
- `i_msi_data`  in  32  MSI payload (interrupt identity)
- `o_setipnum`  out  NR_SRC_WIDTH  identity being delivered
- `o_setipnum_vld`  out  NR_TOTAL_INTFS  one-hot target file strobe
- `o_msi_err`  out  1  one-cycle pulse when an accepted write is dropped
- `o_busy`  out  1  FIFO non-empty or FSM not IDLE

## Operation
- Flat file index `fidx = (i_msi_addr - BASE_ADDR) >> 12`; one 4 KiB page per file.
  - Indices 0..NR_HARTS-1 are the M files of harts 0..NR_HARTS-1.
  - For hart h, the S file is at NR_HARTS+(NR_INTP_FILES-1)*h and VSk follows it at +k.
- Transfer occurs when `i_msi_vld & o_msi_rdy`. `o_msi_rdy = ~fifo_full`; there is no same-cycle pop bypass.
- A transfer is dropped (not enqueued, `o_msi_err` pulses the next cycle) if any of these hold:
  - `i_msi_addr < BASE_ADDR`
  - `fidx >= NR_TOTAL_INTFS`
  - `i_msi_addr[11:0] != 0`
  - `i_msi_data == 0`
  - `i_msi_data >= NR_SRC`
- Otherwise `{fidx, i_msi_data[NR_SRC_WIDTH-1:0]}` is pushed.
- FSM states:
  - IDLE: if FIFO is non-empty, pop the head, load `o_setipnum`, set `o_setipnum_vld = 1<<fidx`, set cnt=HOLD_CYCLES-1, go to DRIVE.
  - DRIVE: vld held. If cnt==0, clear vld, set cnt=GAP_CYCLES-1, go to GAP; else decrement cnt.
  - GAP: vld low, `o_setipnum` unchanged. If cnt==0, go to IDLE; else decrement cnt.
- Exactly one file is strobed at a time. `o_setipnum` is stable from the first vld-high cycle through the end of GAP.
- Back-to-back messages to the same file always show a low phase of ≥GAP_CYCLES.
- Subtraction and comparison use ADDR_WIDTH unsigned arithmetic. `fidx` is truncated to $clog2(NR_TOTAL_INTFS) bits only after the range check.

## Timing
- Reset values:
  - `o_setipnum`=0, `o_setipnum_vld`=0, `o_msi_err`=0, `o_busy`=0
  - `o_msi_rdy`=1
  - FIFO empty, FSM=IDLE, cnt=0
- Latency: with the FSM in IDLE and the FIFO empty, an accept in cycle N raises `o_setipnum_vld` in cycle N+2.
- Throughput: one message per HOLD_CYCLES+1+GAP_CYCLES cycles; the IDLE pop cycle adds 1.
- Full FIFO: `o_msi_rdy`=0. A pop in cycle N makes rdy=1 in cycle N+1.
- Simultaneous push and pop on a non-full FIFO: both occur and the level is unchanged.
- Integration requirement: HOLD_CYCLES and GAP_CYCLES must each cover ≥3 cycles of the slowest destination hart clock.
- `rstn` assertion mid-DRIVE: `o_setipnum_vld` drops asynchronously and buffered messages are discarded.

## Structure
- Shared package `imsic_pkg` holds:
  - page shift constant (12)
  - FIFO entry typedef `{fidx, setipnum}`
  - FSM state enum IDLE/DRIVE/GAP
- Sub-module `imsic_msi_fifo`: synchronous FIFO with parameters FIFO_DEPTH and width. It provides full/empty flags, uses async active-low reset, and has no bypass.

## Test plan
- Reset, then one write (addr=BASE+0x5000, data=7), NR_HARTS=4: `o_setipnum_vld`=1<<5 for exactly 4 cycles starting 2 cycles after accept, `o_setipnum`=7, then 4 low cycles.
- Write data=0, data=32, and addr=BASE+0x5004: each is accepted, `o_msi_err` pulses once, `o_setipnum_vld` never rises.
- Write to fidx=28 (NR_TOTAL_INTFS): dropped with err; a following write to fidx=27 is delivered on bit 27.
- Six back-to-back writes to file 0 (data 1..6) with vld held:
  - `o_msi_rdy` drops after 4 are buffered.
  - All 6 are delivered in order, each with a 4-cycle high and ≥4-cycle low phase.
- Drop `rstn` during DRIVE with 3 messages buffered: outputs return to reset values immediately; after release, no stale message is delivered.
- Push and pop in the same cycle with the FIFO at level 2: level stays 2 and no message is lost or reordered.

Source files
------------

// File: rtl/imsic_pkg.sv
// Shared definitions for the IMSIC MSI dispatcher.
//   PAGE_SHIFT  : one 4 KiB MMIO page per interrupt file
//   msi_entry_t : buffered message {flat file index, interrupt identity}.
//                 Fields are sized for the largest supported configuration
//                 (1024 files, 2048 identities); users zero-extend into them.
//   state_t     : delivery FSM states
package imsic_pkg;

  localparam int PAGE_SHIFT = 12;
  localparam int FIDX_MAX_W = 10;
  localparam int ID_MAX_W   = 11;

  typedef struct packed {
    logic [FIDX_MAX_W-1:0] fidx;
    logic [ID_MAX_W-1:0]   setipnum;
  } msi_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/imsic_msi_dispatch_if.sv
// MSI write bus between an interconnect (master) and the dispatcher (slave).
//   msi_vld  : write valid
//   msi_rdy  : write ready (transfer when vld & rdy)
//   msi_addr : target address, selects the interrupt file page
//   msi_data : payload, the interrupt identity
interface imsic_msi_dispatch_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  msi_vld;
  logic                  msi_rdy;
  logic [ADDR_WIDTH-1:0] msi_addr;
  logic [31:0]           msi_data;

  modport master (output msi_vld, output msi_addr, output msi_data, input msi_rdy);
  modport slave  (input msi_vld, input msi_addr, input msi_data, output msi_rdy);
endinterface

// File: rtl/imsic_msi_fifo.sv
// Synchronous FIFO without bypass. Pushing while full or popping while empty
// is the caller's responsibility to avoid.
//   clk, rstn     : clock, asynchronous active-low reset (pointers only)
//   push, wdata   : write strobe and data
//   pop, rdata    : read strobe and head-of-queue data (valid when !empty)
//   full, empty   : level flags
module imsic_msi_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [PTR_W:0]   wptr;
  logic [PTR_W:0]   rptr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[PTR_W-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[PTR_W-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[PTR_W] != rptr[PTR_W]) &&
                 (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);

endmodule

// File: rtl/imsic_msi_dispatch.sv
// MSI dispatcher: decodes MSI writes into {interrupt file, identity}, buffers
// them, and replays each as a shared setipnum plus a one-hot strobe held high
// for HOLD_CYCLES and followed by at least GAP_CYCLES low, so slower hart
// domains can synchronise and edge-detect every message.
//   clk, rstn       : clock, asynchronous active-low reset
//   msi             : MSI write bus (slave side)
//   o_setipnum      : identity being delivered
//   o_setipnum_vld  : one-hot target file strobe
//   o_msi_err       : one-cycle pulse after an accepted write is dropped
//   o_busy          : messages buffered or delivery in progress
module imsic_msi_dispatch
  import imsic_pkg::*;
#(
  parameter int                    NR_INTP_FILES  = 7,
  parameter int                    NR_HARTS       = 4,
  parameter int                    NR_SRC         = 32,
  parameter int                    NR_SRC_WIDTH   = $clog2(NR_SRC),
  parameter int                    NR_TOTAL_INTFS = NR_HARTS * NR_INTP_FILES,
  parameter int                    ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    FIFO_DEPTH     = 4,
  parameter int                    HOLD_CYCLES    = 4,
  parameter int                    GAP_CYCLES     = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  imsic_msi_dispatch_if.slave       msi,
  output logic [NR_SRC_WIDTH-1:0]   o_setipnum,
  output logic [NR_TOTAL_INTFS-1:0] o_setipnum_vld,
  output logic                      o_msi_err,
  output logic                      o_busy
);

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] fidx_full;
  logic                  drop;
  logic                  xfer;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  msi_entry_t            wr_entry;
  msi_entry_t            head;
  logic                  unused_head_bits;
  state_t                state;
  logic [CNT_W-1:0]      cnt;

  // Decode: range check on the full-width index, truncation only afterwards.
  assign offset    = msi.msi_addr - BASE_ADDR;
  assign fidx_full = offset >> PAGE_SHIFT;
  assign drop = (msi.msi_addr < BASE_ADDR) ||
                (fidx_full >= ADDR_WIDTH'(NR_TOTAL_INTFS)) ||
                (msi.msi_addr[PAGE_SHIFT-1:0] != '0) ||
                (msi.msi_data == 32'd0) ||
                (msi.msi_data >= 32'(NR_SRC));

  assign msi.msi_rdy       = ~full;
  assign xfer              = msi.msi_vld & ~full;
  assign push              = xfer & ~drop;
  assign wr_entry.fidx     = FIDX_MAX_W'(fidx_full);
  assign wr_entry.setipnum = ID_MAX_W'(msi.msi_data[NR_SRC_WIDTH-1:0]);

  imsic_msi_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      ($bits(msi_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Identity bits above NR_SRC_WIDTH are always zero by construction.
  assign unused_head_bits = ^head.setipnum[ID_MAX_W-1:NR_SRC_WIDTH];

  assign pop    = (state == IDLE) && !empty;
  assign o_busy = !empty || (state != IDLE);

  // Delivery FSM: pop in IDLE, hold the strobe in DRIVE, enforce the low phase in GAP.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      cnt            <= '0;
      o_setipnum     <= '0;
      o_setipnum_vld <= '0;
      o_msi_err      <= 1'b0;
    end else begin
      o_msi_err <= xfer & drop;
      case (state)
        IDLE: begin
          if (!empty) begin
            o_setipnum     <= head.setipnum[NR_SRC_WIDTH-1:0];
            o_setipnum_vld <= NR_TOTAL_INTFS'(1) << head.fidx;
            cnt            <= CNT_W'(HOLD_CYCLES - 1);
            state          <= DRIVE;
          end
        end
        DRIVE: begin
          if (cnt == '0) begin
            o_setipnum_vld <= '0;
            cnt            <= CNT_W'(GAP_CYCLES - 1);
            state          <= GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imsic_msi_dispatch.sv
module tb_imsic_msi_dispatch;

  localparam int          NR_INTP_FILES  = 7;
  localparam int          NR_HARTS       = 4;
  localparam int          NR_SRC         = 32;
  localparam int          NR_SRC_WIDTH   = 5;
  localparam int          NR_TOTAL_INTFS = NR_HARTS * NR_INTP_FILES;
  localparam int          ADDR_WIDTH     = 32;
  localparam logic [31:0] BASE_ADDR      = 32'h2800_0000;
  localparam int          FIFO_DEPTH     = 4;
  localparam int          HOLD_CYCLES    = 4;
  localparam int          GAP_CYCLES     = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  imsic_msi_dispatch_if #(.ADDR_WIDTH(ADDR_WIDTH)) msi_bus ();

  logic [NR_SRC_WIDTH-1:0]   setipnum;
  logic [NR_TOTAL_INTFS-1:0] setipnum_vld;
  logic                      msi_err;
  logic                      busy;

  imsic_msi_dispatch #(
    .NR_INTP_FILES (NR_INTP_FILES),
    .NR_HARTS      (NR_HARTS),
    .NR_SRC        (NR_SRC),
    .NR_SRC_WIDTH  (NR_SRC_WIDTH),
    .NR_TOTAL_INTFS(NR_TOTAL_INTFS),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .BASE_ADDR     (BASE_ADDR),
    .FIFO_DEPTH    (FIFO_DEPTH),
    .HOLD_CYCLES   (HOLD_CYCLES),
    .GAP_CYCLES    (GAP_CYCLES)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .msi            (msi_bus),
    .o_setipnum     (setipnum),
    .o_setipnum_vld (setipnum_vld),
    .o_msi_err      (msi_err),
    .o_busy         (busy)
  );

  typedef struct {
    int fidx;
    int id;
    int rise;  // expected cycle of the strobe's first high cycle, -1 = unchecked
  } exp_t;

  exp_t exp_q[$];
  int   err_exp     = 0;
  int   checks      = 0;
  int   errors      = 0;
  int   cyc         = 0;
  int   acc_total   = 0;
  int   rdy_low_at  = -1;
  int   delivered   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: decode straight from the address map rules.
  task automatic model_accept(input logic [31:0] a, input logic [31:0] d, input int rise);
    longint off;
    bit     bad;
    off = longint'(a) - longint'(BASE_ADDR);
    bad = (off < 0) || ((off / 4096) >= NR_TOTAL_INTFS) || ((a % 4096) != 0) ||
          (d == 0) || (d >= NR_SRC);
    acc_total++;
    if (bad) err_exp++;
    else     exp_q.push_back('{fidx: int'(off / 4096), id: int'(d), rise: rise});
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d, input bit lat);
    int waitc;
    bit ok;
    waitc = 0;
    ok = 1'b0;
    msi_bus.msi_vld  = 1'b1;
    msi_bus.msi_addr = a;
    msi_bus.msi_data = d;
    while (!ok) begin
      @(negedge clk);
      if (msi_bus.msi_rdy) begin
        ok = 1'b1;
        model_accept(a, d, lat ? cyc + 2 : -1);
      end else begin
        if (rdy_low_at < 0) rdy_low_at = acc_total;
        waitc++;
        if (waitc > 200) begin
          check(1'b0, "rdy_timeout", waitc, 200);
          ok = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    msi_bus.msi_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || err_exp != 0 || setipnum_vld != '0) && n < 1000) begin
      idle(1);
      n++;
    end
    check(n < 1000, "drain_timeout", n, 1000);
    idle(GAP_CYCLES + 2);
  endtask

  // Monitor: pops the scoreboard on each rising strobe, checks shape and timing.
  logic [NR_TOTAL_INTFS-1:0] prev_vld;
  int                        high_cnt;
  int                        low_cnt;
  bit                        have_last;
  logic [NR_SRC_WIDTH-1:0]   last_id;
  exp_t                      e;

  always @(negedge clk) begin
    if (!rstn) begin
      prev_vld  = '0;
      high_cnt  = 0;
      low_cnt   = GAP_CYCLES;
      have_last = 1'b0;
    end else begin
      if (msi_err) begin
        check(err_exp > 0, "err_unexpected", 1, 0);
        if (err_exp > 0) err_exp--;
      end
      if (setipnum_vld != '0 && prev_vld == '0) begin
        check($onehot(setipnum_vld), "vld_onehot", longint'(setipnum_vld), 1);
        if (have_last) check(low_cnt >= GAP_CYCLES, "gap_len", low_cnt, GAP_CYCLES);
        if (exp_q.size() == 0) begin
          check(1'b0, "msg_unexpected", longint'(setipnum_vld), 0);
        end else begin
          e = exp_q.pop_front();
          check(setipnum_vld == (NR_TOTAL_INTFS'(1) << e.fidx), "vld_target",
                longint'(setipnum_vld), longint'(1) << e.fidx);
          check(int'(setipnum) == e.id, "setipnum", setipnum, e.id);
          if (e.rise >= 0) check(cyc == e.rise, "latency_cycle", cyc, e.rise);
        end
        high_cnt  = 1;
        last_id   = setipnum;
        have_last = 1'b1;
        delivered++;
      end else if (setipnum_vld != '0) begin
        check(setipnum_vld == prev_vld && setipnum == last_id, "hold_stable",
              longint'(setipnum_vld), longint'(prev_vld));
        high_cnt++;
      end else if (prev_vld != '0) begin
        check(high_cnt == HOLD_CYCLES, "hold_len", high_cnt, HOLD_CYCLES);
        low_cnt = 1;
      end else begin
        if (have_last && low_cnt < GAP_CYCLES)
          check(setipnum == last_id, "gap_setipnum_stable", setipnum, last_id);
        low_cnt++;
      end
      prev_vld = setipnum_vld;
    end
  end

  initial begin
    int d0;
    logic [31:0] a;
    logic [31:0] d;
    msi_bus.msi_vld  = 1'b0;
    msi_bus.msi_addr = '0;
    msi_bus.msi_data = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check(setipnum == '0, "rst_setipnum", setipnum, 0);
    check(setipnum_vld == '0, "rst_vld", longint'(setipnum_vld), 0);
    check(msi_err == 1'b0, "rst_err", msi_err, 0);
    check(busy == 1'b0, "rst_busy", busy, 0);
    check(msi_bus.msi_rdy == 1'b1, "rst_rdy", msi_bus.msi_rdy, 1);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(2);

    // Single write with latency check
    write(BASE_ADDR + 32'h5000, 32'd7, 1'b1);
    wait_drain();

    // Dropped writes: bad identity, misaligned, out of range, below base
    write(BASE_ADDR + 32'h5000, 32'd0, 1'b0);
    write(BASE_ADDR + 32'h5000, 32'd32, 1'b0);
    write(BASE_ADDR + 32'h5004, 32'd3, 1'b0);
    write(BASE_ADDR + 32'h1C000, 32'd9, 1'b0);
    write(BASE_ADDR - 32'h1000, 32'd9, 1'b0);
    idle(3);
    check(err_exp == 0, "err_pulses_seen", err_exp, 0);
    write(BASE_ADDR + 32'h1B000, 32'd31, 1'b1);
    wait_drain();

    // Six back-to-back writes to file 0: one pops, four fill the FIFO
    rdy_low_at = -1;
    d0 = acc_total;
    for (int i = 1; i <= 6; i++) write(BASE_ADDR, 32'(i), 1'b0);
    check(rdy_low_at == d0 + FIFO_DEPTH + 1, "rdy_drop_point", rdy_low_at - d0, FIFO_DEPTH + 1);
    wait_drain();

    // Push and pop in the same cycle at level 2
    write(BASE_ADDR + 32'h2000, 32'd11, 1'b1);
    write(BASE_ADDR + 32'h3000, 32'd12, 1'b0);
    write(BASE_ADDR + 32'h4000, 32'd13, 1'b0);
    idle(HOLD_CYCLES + GAP_CYCLES - 1);
    write(BASE_ADDR + 32'h6000, 32'd14, 1'b0);
    wait_drain();

    // Reset during DRIVE with three messages buffered
    for (int i = 0; i < 4; i++) write(BASE_ADDR + 32'(i * 32'h1000), 32'(20 + i), 1'b0);
    check(setipnum_vld != '0, "pre_rst_driving", longint'(setipnum_vld), 1);
    rstn = 1'b0;
    #1;
    check(setipnum_vld == '0, "midrst_vld", longint'(setipnum_vld), 0);
    check(setipnum == '0, "midrst_setipnum", setipnum, 0);
    check(busy == 1'b0, "midrst_busy", busy, 0);
    check(msi_bus.msi_rdy == 1'b1, "midrst_rdy", msi_bus.msi_rdy, 1);
    exp_q.delete();
    err_exp = 0;
    idle(2);
    rstn = 1'b1;
    d0 = delivered;
    idle(40);
    check(delivered == d0, "no_stale_msg", delivered - d0, 0);
    write(BASE_ADDR + 32'h8000, 32'd5, 1'b1);
    wait_drain();

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      a = BASE_ADDR + 32'($urandom_range(0, 29)) * 32'h1000;
      if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 4095));
      if ($urandom_range(0, 14) == 0) a = BASE_ADDR - 32'($urandom_range(1, 3)) * 32'h1000;
      d = 32'($urandom_range(0, 33));
      write(a, d, 1'b0);
      idle($urandom_range(0, 12));
    end
    wait_drain();
    check(exp_q.size() == 0, "final_queue_empty", exp_q.size(), 0);
    check(busy == 1'b0, "final_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
